alu_control: RTL and testbench
==============================

// Module: alu_control
// PURPOSE
// - Main-decoder-to-ALU opcode translator for the single-cycle RV32 core; sits between the control unit and the ALU.
// - Combines the 2-bit aluOp class with instruction funct3/funct7 bits to select an ALUOpcode::t_e operation (Shared package).
// - Adds a registered sticky illegal-decode flag for debug/trap logic.
// PARAMETERS
// - none (opcode set fixed by Shared::ALUOpcode::t_e)
// PORTS
// - clk           in   1  system clock, rising edge; single clock domain
// - rst           in   1  asynchronous, active-high reset
// - funct7Parts   in   2  [1]=instr funct7[5] (alt op: SUB/SRA), [0]=instr funct7[0] (M-extension)
// - funct3        in   3  instr funct3
// - aluOp         in   2  00 load/store/addr, 01 branch, 10 R-type, 11 I-type ALU
// - clearIllegal  in   1  synchronous clear of illegalSticky
// - aluOpcode     out  ALUOpcode::t_e  selected ALU operation (combinational)
// - illegal       out  1  current inputs form an unsupported combination (combinational)
// - illegalSticky out  1  registered: set once any illegal decode sampled
// BEHAVIOUR
// - aluOpcode/illegal purely combinational, zero latency; independent of clk/rst.
// - aluOp=00: ADD regardless of funct3/funct7Parts; illegal=0.
// - aluOp=01 (branch, compare only; branch unit applies inversion):
//   funct3 000/001 -> EQ; 100/101 -> LT; 110/111 -> LTU; 010/011 -> EQ with illegal=1.
// - aluOp=10 (R-type), funct7Parts[0]=0:
//   000 -> funct7Parts[1] ? SUB : ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR;
//   101 -> funct7Parts[1] ? SRA : SRL; 110 OR; 111 AND.
//   funct7Parts[1]=1 with funct3 not 000/101 -> base op, illegal=1.
// - aluOp=11 (I-type): funct7Parts[1] ignored except funct3=101 (SRAI vs SRLI);
//   000 ADD (never SUB); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA; 110 OR; 111 AND.
//   funct7Parts[0] ignored for aluOp=11.
// - Unhandled/illegal combinations must never produce X: output the stated default.
// - illegalSticky: async reset to 0; on posedge clk, if illegal=1 -> 1 (set wins over
//   simultaneous clearIllegal); else if clearIllegal -> 0; else hold.
// - rst asserted mid-operation: illegalSticky forced 0 immediately; combinational outputs unaffected.
// CONFIGURATION
// - ALU_CONTROL_MEXT_EN defined: aluOp=10 with funct7Parts[0]=1 decodes RV32M by funct3:
//   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; illegal=0
//   (funct7Parts[1]=1 also set -> ADD, illegal=1).
// - Not defined: funct7Parts[0]=1 with aluOp=10 -> ADD, illegal=1; M opcodes never emitted.
// TESTING
// - funct7Parts=0, funct3=0, aluOp=00 -> aluOpcode=ADD, illegal=0.
// - funct3=1, aluOp=01 -> EQ; funct3=6, aluOp=01 -> LTU; funct3=2, aluOp=01 -> EQ, illegal=1.
// - funct7Parts=2, funct3=0, aluOp=10 -> SUB; same with aluOp=11 -> ADD; funct3=5 aluOp=11 -> SRA.
// - funct7Parts=0, funct3=6, aluOp=11 -> OR; funct3=7 aluOp=10 -> AND.
// - rst pulse -> illegalSticky=0; drive illegal case 1 clk -> illegalSticky=1 holds after legal inputs;
//   clearIllegal with legal inputs -> 0; clearIllegal with illegal inputs same edge -> stays 1.
// - funct7Parts=1, funct3=4, aluOp=10 -> DIV (with ALU_CONTROL_MEXT_EN) else ADD with illegal=1.

Source files
------------

// File: rtl/alu_control.sv
// ALU control decoder: aluOp class + funct3/funct7 bits -> ALU operation, plus a sticky illegal flag.
// Define ALU_CONTROL_MEXT_EN to decode the RV32M multiply/divide group.
package alu_control_pkg;
   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_SLL    = 5'd2,
      ALU_SLT    = 5'd3,
      ALU_SLTU   = 5'd4,
      ALU_XOR    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_OR     = 5'd8,
      ALU_AND    = 5'd9,
      ALU_EQ     = 5'd10,
      ALU_LT     = 5'd11,
      ALU_LTU    = 5'd12,
      ALU_MUL    = 5'd13,
      ALU_MULH   = 5'd14,
      ALU_MULHSU = 5'd15,
      ALU_MULHU  = 5'd16,
      ALU_DIV    = 5'd17,
      ALU_DIVU   = 5'd18,
      ALU_REM    = 5'd19,
      ALU_REMU   = 5'd20
   } alu_opcode_e;
endpackage

module alu_control
   import alu_control_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  funct7Parts,
   input  logic [2:0]  funct3,
   input  logic [1:0]  aluOp,
   input  logic        clearIllegal,
   output alu_opcode_e aluOpcode,
   output logic        illegal,
   output logic        illegalSticky
);

   alu_opcode_e opcode_d;
   alu_opcode_e base_op;
   logic        illegal_d;
   logic        illegal_sticky_q;

   // Shared base-integer decode for R-type and I-type by funct3.
   always_comb begin
      base_op = ALU_ADD;
      case (funct3)
         3'b000:  base_op = ALU_ADD;
         3'b001:  base_op = ALU_SLL;
         3'b010:  base_op = ALU_SLT;
         3'b011:  base_op = ALU_SLTU;
         3'b100:  base_op = ALU_XOR;
         3'b101:  base_op = ALU_SRL;
         3'b110:  base_op = ALU_OR;
         default: base_op = ALU_AND;
      endcase
   end

   always_comb begin
      opcode_d  = ALU_ADD;
      illegal_d = 1'b0;
      case (aluOp)
         2'b00: begin
            opcode_d = ALU_ADD;
         end
         2'b01: begin
            // Compare only; the branch unit handles BNE/BGE/BGEU inversion.
            case (funct3)
               3'b000, 3'b001: opcode_d = ALU_EQ;
               3'b010, 3'b011: begin
                  opcode_d  = ALU_EQ;
                  illegal_d = 1'b1;
               end
               3'b100, 3'b101: opcode_d = ALU_LT;
               default:        opcode_d = ALU_LTU;
            endcase
         end
         2'b10: begin
            if (funct7Parts[0]) begin
`ifdef ALU_CONTROL_MEXT_EN
               if (funct7Parts[1]) begin
                  opcode_d  = ALU_ADD;
                  illegal_d = 1'b1;
               end else begin
                  case (funct3)
                     3'b000:  opcode_d = ALU_MUL;
                     3'b001:  opcode_d = ALU_MULH;
                     3'b010:  opcode_d = ALU_MULHSU;
                     3'b011:  opcode_d = ALU_MULHU;
                     3'b100:  opcode_d = ALU_DIV;
                     3'b101:  opcode_d = ALU_DIVU;
                     3'b110:  opcode_d = ALU_REM;
                     default: opcode_d = ALU_REMU;
                  endcase
               end
`else
               opcode_d  = ALU_ADD;
               illegal_d = 1'b1;
`endif
            end else if (funct7Parts[1]) begin
               if (funct3 == 3'b000) begin
                  opcode_d = ALU_SUB;
               end else if (funct3 == 3'b101) begin
                  opcode_d = ALU_SRA;
               end else begin
                  opcode_d  = base_op;
                  illegal_d = 1'b1;
               end
            end else begin
               opcode_d = base_op;
            end
         end
         default: begin
            if (funct3 == 3'b101 && funct7Parts[1]) begin
               opcode_d = ALU_SRA;
            end else begin
               opcode_d = base_op;
            end
         end
      endcase
   end

   assign aluOpcode = opcode_d;
   assign illegal   = illegal_d;

   // Setting wins over a clear arriving on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_sticky_q <= 1'b0;
      end else if (illegal_d) begin
         illegal_sticky_q <= 1'b1;
      end else if (clearIllegal) begin
         illegal_sticky_q <= 1'b0;
      end
   end

   assign illegalSticky = illegal_sticky_q;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: random + directed decode against a table-driven reference model.
module tb_alu_control;
  import alu_control_pkg::*;

  localparam int W = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  funct7_parts = '0;
  logic [2:0]  funct3 = '0;
  logic [1:0]  alu_op = '0;
  logic        clear_illegal = 1'b0;
  alu_opcode_e alu_opcode;
  logic        illegal;
  logic        illegal_sticky;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic model_sticky = 1'b0;
  logic prev_illegal = 1'b0;
  logic prev_clr = 1'b0;

  alu_opcode_e base_tbl[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  alu_opcode_e br_tbl[8]   = '{ALU_EQ, ALU_EQ, ALU_EQ, ALU_EQ, ALU_LT, ALU_LT, ALU_LTU, ALU_LTU};
  alu_opcode_e m_tbl[8]    = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

  alu_control dut (
    .clk           (clk),
    .rst           (rst),
    .funct7Parts   (funct7_parts),
    .funct3        (funct3),
    .aluOp         (alu_op),
    .clearIllegal  (clear_illegal),
    .aluOpcode     (alu_opcode),
    .illegal       (illegal),
    .illegalSticky (illegal_sticky)
  );

  // clock
  always #5 clk = ~clk;

  // reference model: instruction-class rules
  task automatic ref_model(input logic [1:0] f7, input logic [2:0] f3, input logic [1:0] op,
                           output alu_opcode_e opc, output logic ill);
    opc = ALU_ADD;
    ill = 1'b0;
    if (op == 2'd1) begin
      opc = br_tbl[f3];
      ill = (f3 == 3'd2) || (f3 == 3'd3);
    end else if (op == 2'd2) begin
      if (f7[0]) begin
`ifdef ALU_CONTROL_MEXT_EN
        if (f7[1]) ill = 1'b1;
        else       opc = m_tbl[f3];
`else
        ill = 1'b1;
`endif
      end else if (f7[1] && f3 == 3'd0) begin
        opc = ALU_SUB;
      end else if (f7[1] && f3 == 3'd5) begin
        opc = ALU_SRA;
      end else begin
        opc = base_tbl[f3];
        ill = f7[1];
      end
    end else if (op == 2'd3) begin
      opc = (f3 == 3'd5 && f7[1]) ? ALU_SRA : base_tbl[f3];
    end
  endtask

  // driver: one stimulus per cycle, expected value pushed when issued
  task automatic drive(input logic [1:0] f7, input logic [2:0] f3, input logic [1:0] op, input logic clr);
    alu_opcode_e e_opc;
    logic e_ill;
    @(posedge clk);
    if (prev_illegal)  model_sticky = 1'b1;
    else if (prev_clr) model_sticky = 1'b0;
    #1;
    funct7_parts  = f7;
    funct3        = f3;
    alu_op        = op;
    clear_illegal = clr;
    ref_model(f7, f3, op, e_opc, e_ill);
    prev_illegal = e_ill;
    prev_clr     = clr;
    exp_q.push_back({e_opc, e_ill, model_sticky});
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    if (prev_illegal)  model_sticky = 1'b1;
    else if (prev_clr) model_sticky = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_sticky = 1'b0;
    checks++;
    if (illegal_sticky !== model_sticky) begin
      errors++;
      $display("FAIL async_reset: illegalSticky got %b expected %b", illegal_sticky, model_sticky);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // monitor: combinational outputs are presented every cycle a stimulus is pending
  initial begin
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {alu_opcode, illegal, illegal_sticky};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL decode f7=%b f3=%0d op=%0d clr=%b: got opc=%0d ill=%b sticky=%b expected opc=%0d ill=%b sticky=%b",
                   funct7_parts, funct3, alu_op, clear_illegal,
                   got_v[6:2], got_v[1], got_v[0], exp_v[6:2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    int waited;
    #1;
    checks++;
    if (illegal_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: illegalSticky got %b expected 0", illegal_sticky);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    // directed decode cases
    drive(2'd0, 3'd0, 2'd0, 1'b0);
    drive(2'd0, 3'd1, 2'd1, 1'b0);
    drive(2'd0, 3'd6, 2'd1, 1'b0);
    drive(2'd2, 3'd0, 2'd2, 1'b0);
    drive(2'd2, 3'd0, 2'd3, 1'b0);
    drive(2'd2, 3'd5, 2'd3, 1'b0);
    drive(2'd0, 3'd6, 2'd3, 1'b0);
    drive(2'd0, 3'd7, 2'd2, 1'b0);
    drive(2'd3, 3'd7, 2'd0, 1'b0);
    drive(2'd2, 3'd3, 2'd3, 1'b0);
    drive(2'd1, 3'd0, 2'd3, 1'b0);

    // sticky sequence: set, hold, clear, set-beats-clear
    pulse_reset();
    drive(2'd0, 3'd2, 2'd1, 1'b0);
    drive(2'd0, 3'd0, 2'd0, 1'b0);
    drive(2'd0, 3'd0, 2'd0, 1'b0);
    drive(2'd0, 3'd0, 2'd0, 1'b1);
    drive(2'd0, 3'd0, 2'd0, 1'b0);
    drive(2'd2, 3'd1, 2'd2, 1'b1);
    drive(2'd0, 3'd0, 2'd0, 1'b0);
    drive(2'd1, 3'd4, 2'd2, 1'b0);
    drive(2'd3, 3'd4, 2'd2, 1'b0);
    drive(2'd0, 3'd0, 2'd0, 1'b1);
    drive(2'd0, 3'd0, 2'd0, 1'b0);

    // exhaustive sweep of decode inputs
    for (int i = 0; i < 128; i++) begin
      drive(i[6:5], i[4:2], i[1:0], 1'b0);
    end

    // random stimulus with occasional clears and resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) pulse_reset();
      drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0));
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
